// File: rtl/bus_sequencer_pkg.sv
// Shared constants for the bus sequencer: state codes, unit indices, IR field
// positions and the decode rule that classifies an instruction.
package bus_sequencer_pkg;

   localparam logic [2:0] SEQ_IDLE   = 3'd0;
   localparam logic [2:0] SEQ_FETCH  = 3'd1;
   localparam logic [2:0] SEQ_DECODE = 3'd2;
   localparam logic [2:0] SEQ_EXEC   = 3'd3;
   localparam logic [2:0] SEQ_HALT   = 3'd4;
   localparam logic [2:0] SEQ_FAULT  = 3'd5;

   localparam int INDEX_EN_IR    = 1;
   localparam int INDEX_EN_FETCH = 12;
   localparam int INDEX_EN_SKIN0 = 13;
   localparam int INDEX_EN_SKIN1 = 14;
   localparam int INDEX_EN_BAD   = 15;

   localparam int DST_FIRST = 1;
   localparam int DST_LAST  = 6;

   localparam int SRC_MSB = 7;
   localparam int SRC_LSB = 4;
   localparam int DST_MSB = 3;
   localparam int DST_LSB = 0;

   localparam logic [7:0] HALT_INSTR = 8'h00;

   function automatic logic is_skin_src(input logic [3:0] src);
      return (src == 4'(INDEX_EN_SKIN0)) || (src == 4'(INDEX_EN_SKIN1));
   endfunction

   // Where DECODE goes next; the HALT encoding is checked before the legality rules.
   function automatic logic [2:0] decode_target(input logic [3:0] src, input logic [3:0] dst);
      logic [2:0] target;
      if ({src, dst} == HALT_INSTR)
         target = SEQ_HALT;
      else if (dst < 4'(DST_FIRST) || dst > 4'(DST_LAST))
         target = SEQ_FAULT;
      else if (src == 4'd0 || src == 4'(INDEX_EN_FETCH) || src == 4'(INDEX_EN_BAD))
         target = SEQ_FAULT;
      else if (src == dst)
         target = SEQ_FAULT;
      else
         target = SEQ_EXEC;
      return target;
   endfunction

endpackage

// File: rtl/bus_sequencer_ack_timer.sv
// Counts cycles spent waiting for a skin-memory ack and flags the last
// permitted wait cycle so the sequencer can fault if no ack arrives in it.
module bus_sequencer_ack_timer #(
   parameter int TIMEOUT_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   // Count holds cycles already waited, so terminal marks wait cycle number 2**W-1.
   localparam logic [TIMEOUT_W-1:0] LAST_WAIT = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   logic [TIMEOUT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && count != '1)
         count <= count + 1'b1;
   end

   assign terminal = (count == LAST_WAIT);

endmodule

// File: rtl/bus_sequencer.sv
// Fetch/execute controller: sequences skin-memory fetches and one-word
// register-file moves by driving one-hot unit load/drive enables.
module bus_sequencer
   import bus_sequencer_pkg::*;
#(
   parameter int TIMEOUT_W = 4,
   parameter int IR_W      = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_start,
   input  logic [IR_W-1:0] i_instruction,
   input  logic            i_skin_ack,
   output logic            o_skin_req,
   output logic [15:0]     o_unit_ien,
   output logic [15:0]     o_unit_oen,
   output logic            o_busy,
   output logic            o_halt,
   output logic            o_fault
);

   logic [2:0] state;
   logic [2:0] next_state;
   logic [3:0] ir_src;
   logic [3:0] ir_dst;
   logic [3:0] exec_src;
   logic [3:0] exec_dst;
   logic       skin_exec;
   logic       waiting;
   logic       timeout;

   assign ir_src    = i_instruction[SRC_MSB:SRC_LSB];
   assign ir_dst    = i_instruction[DST_MSB:DST_LSB];
   assign skin_exec = (state == SEQ_EXEC) && is_skin_src(exec_src);
   assign waiting   = (state == SEQ_FETCH) || skin_exec;

   bus_sequencer_ack_timer #(.TIMEOUT_W(TIMEOUT_W)) u_ack_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (!waiting || i_skin_ack),
      .enable   (waiting && !i_skin_ack),
      .terminal (timeout)
   );

   // Operands are captured in DECODE so EXEC does not depend on IR staying put.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SEQ_IDLE;
         exec_src <= '0;
         exec_dst <= '0;
      end else begin
         state <= next_state;
         if (state == SEQ_DECODE) begin
            exec_src <= ir_src;
            exec_dst <= ir_dst;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         SEQ_IDLE, SEQ_HALT, SEQ_FAULT:
            if (i_start) next_state = SEQ_FETCH;
         SEQ_FETCH:
            if (i_skin_ack)   next_state = SEQ_DECODE;
            else if (timeout) next_state = SEQ_FAULT;
         SEQ_DECODE:
            next_state = decode_target(ir_src, ir_dst);
         SEQ_EXEC:
            if (!skin_exec || i_skin_ack) next_state = SEQ_FETCH;
            else if (timeout)             next_state = SEQ_FAULT;
         default:
            next_state = SEQ_IDLE;
      endcase
   end

   // A late ack on the terminal wait cycle still completes the transfer.
   always_comb begin
      o_skin_req = 1'b0;
      o_unit_ien = '0;
      o_unit_oen = '0;
      case (state)
         SEQ_FETCH: begin
            o_skin_req = 1'b1;
            if (i_skin_ack) begin
               o_unit_oen[INDEX_EN_FETCH] = 1'b1;
               o_unit_ien[INDEX_EN_IR]    = 1'b1;
            end
         end
         SEQ_EXEC: begin
            o_skin_req = skin_exec;
            if (!skin_exec || i_skin_ack) begin
               o_unit_oen[exec_src] = 1'b1;
               o_unit_ien[exec_dst] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign o_busy  = (state == SEQ_FETCH) || (state == SEQ_DECODE) || (state == SEQ_EXEC);
   assign o_halt  = (state == SEQ_HALT);
   assign o_fault = (state == SEQ_FAULT);

endmodule
